seq_alu: RTL and testbench

//  Parametrised, handshaked successor to the 4-op combinational ALU: WIDTH-bit operands, 10 ops incl. iterative MUL/DIVU.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/seq_alu_iter.sv | 86 ++++++++
 rtl/seq_alu.sv | 146 ++++++++++++++
 tb/tb_seq_alu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the sequential ALU.
// Build option SEQ_ALU_DIV_EN enables the DIVU opcode.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_OR   = 4'd2,
      OP_AND  = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLL  = 4'd6,
      OP_SRL  = 4'd7,
      OP_MUL  = 4'd8,
      OP_DIVU = 4'd9
   } op_t;

   localparam int unsigned NUM_FLAGS  = 5;
   localparam int unsigned FLAG_ZERO  = 0;
   localparam int unsigned FLAG_CARRY = 1;
   localparam int unsigned FLAG_OVF   = 2;
   localparam int unsigned FLAG_DZ    = 3;
   localparam int unsigned FLAG_ERR   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ops that run on the multi-cycle datapath instead of the 1-cycle mux.
   function automatic logic is_iter_op(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
      return (op == OP_MUL) || (op == OP_DIVU);
`else
      return (op == OP_MUL);
`endif
   endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: shift-add multiply and (with SEQ_ALU_DIV_EN) restoring divide.
// One step per busy cycle; {hi,lo} holds product or {remainder,quotient} when finished.
module seq_alu_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SEQ_ALU_DIV_EN
   input  logic             is_div,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done_c,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic             busy;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH:0]   mul_sum_c;
   logic [WIDTH-1:0] nxt_lo_c;
   logic [WIDTH-1:0] nxt_hi_c;
`ifdef SEQ_ALU_DIV_EN
   logic             div_mode;
   logic [WIDTH:0]   rsh_c;
   logic [WIDTH-1:0] rdiff_c;
   logic             ge_c;
`endif

   assign done_c = busy && (cnt == CW'(WIDTH - 1));

   // Next {hi,lo}: multiply adds the multiplicand on lo[0] then shifts right;
   // divide shifts left into the remainder and subtracts when it fits.
   always_comb begin
      mul_sum_c = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      nxt_hi_c  = mul_sum_c[WIDTH:1];
      nxt_lo_c  = {mul_sum_c[0], lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
      rsh_c   = {hi, lo[WIDTH-1]};
      ge_c    = rsh_c >= {1'b0, opnd};
      rdiff_c = rsh_c[WIDTH-1:0] - opnd;
      if (div_mode) begin
         nxt_hi_c = ge_c ? rdiff_c : rsh_c[WIDTH-1:0];
         nxt_lo_c = {lo[WIDTH-2:0], ge_c};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         cnt      <= '0;
         lo       <= '0;
         hi       <= '0;
         opnd     <= '0;
`ifdef SEQ_ALU_DIV_EN
         div_mode <= 1'b0;
`endif
      end else if (start) begin
         busy     <= 1'b1;
         cnt      <= '0;
         lo       <= a;
         hi       <= '0;
         opnd     <= b;
`ifdef SEQ_ALU_DIV_EN
         div_mode <= is_div;
`endif
      end else if (busy) begin
         lo <= nxt_lo_c;
         hi <= nxt_hi_c;
         if (done_c) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: 1-cycle logic/arith ops plus iterative MUL/DIVU.
// Build option SEQ_ALU_DIV_EN enables DIVU (op 9); otherwise op 9 reports err.
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ans,
   output logic [WIDTH-1:0] ans_hi,
   output logic [4:0]       flags
);

   localparam int unsigned SHW = $clog2(WIDTH);

   state_t               state;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [3:0]           op_q;
   logic                 accept_c;
   logic                 start_c;
   logic                 iter_done_c;
   logic [WIDTH-1:0]     iter_lo;
   logic [WIDTH-1:0]     iter_hi;
   logic [WIDTH:0]       sum_c;
   logic [WIDTH:0]       diff_c;
   logic [WIDTH-1:0]     res_lo_c;
   logic [WIDTH-1:0]     res_hi_c;
   logic [NUM_FLAGS-1:0] res_flags_c;

   assign accept_c = in_valid & in_ready;
   assign start_c  = accept_c & is_iter_op(op);

   seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_c),
`ifdef SEQ_ALU_DIV_EN
      .is_div (op == OP_DIVU),
`endif
      .a      (inA),
      .b      (inB),
      .done_c (iter_done_c),
      .lo     (iter_lo),
      .hi     (iter_hi)
   );

   assign sum_c  = {1'b0, a_q} + {1'b0, b_q};
   assign diff_c = {1'b0, a_q} - {1'b0, b_q};

   // Result and flags from the latched operands; the iterative ops just forward the datapath.
   always_comb begin
      res_lo_c    = '0;
      res_hi_c    = '0;
      res_flags_c = '0;
      case (op_q)
         OP_ADD: begin
            res_lo_c               = sum_c[WIDTH-1:0];
            res_flags_c[FLAG_CARRY] = sum_c[WIDTH];
            res_flags_c[FLAG_OVF]   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                      (sum_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            res_lo_c               = diff_c[WIDTH-1:0];
            res_flags_c[FLAG_CARRY] = diff_c[WIDTH];
            res_flags_c[FLAG_OVF]   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (diff_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_OR:  res_lo_c = a_q | b_q;
         OP_AND: res_lo_c = a_q & b_q;
         OP_XOR: res_lo_c = a_q ^ b_q;
         OP_SLT: res_lo_c = WIDTH'($signed(a_q) < $signed(b_q));
         OP_SLL: res_lo_c = a_q << b_q[SHW-1:0];
         OP_SRL: res_lo_c = a_q >> b_q[SHW-1:0];
         OP_MUL: begin
            res_lo_c = iter_lo;
            res_hi_c = iter_hi;
         end
`ifdef SEQ_ALU_DIV_EN
         OP_DIVU: begin
            res_lo_c             = iter_lo;
            res_hi_c             = iter_hi;
            res_flags_c[FLAG_DZ] = (b_q == '0);
         end
`endif
         default: res_flags_c[FLAG_ERR] = 1'b1;
      endcase
      res_flags_c[FLAG_ZERO] = !res_flags_c[FLAG_ERR] && ({res_hi_c, res_lo_c} == '0);
   end

   // DONE spends its first cycle registering the result, then holds it until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         ans       <= '0;
         ans_hi    <= '0;
         flags     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  a_q      <= inA;
                  b_q      <= inB;
                  op_q     <= op;
                  in_ready <= 1'b0;
                  state    <= is_iter_op(op) ? BUSY : DONE;
               end
            end
            BUSY: begin
               if (iter_done_c) state <= DONE;
            end
            DONE: begin
               if (!out_valid) begin
                  ans       <= res_lo_c;
                  ans_hi    <= res_hi_c;
                  flags     <= res_flags_c;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=8): directed vector table, handshake corner sequences, random ops vs model.
// Follows SEQ_ALU_DIV_EN the same way the design does.
module tb_seq_alu;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] inA = '0;
   logic [7:0] inB = '0;
   logic [3:0] op = '0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] ans;
   logic [7:0] ans_hi;
   logic [4:0] flags;

   int n_cmp = 0;
   int n_bad = 0;

   seq_alu #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inA       (inA),
      .inB       (inB),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ans       (ans),
      .ans_hi    (ans_hi),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] ans;
      logic [7:0] hi;
      logic [4:0] fl;
      int         lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected result straight from the arithmetic definition of each op.
   function automatic void model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] e_ans, output logic [7:0] e_hi,
                                 output logic [4:0] e_fl, output int e_lat);
      int ia, ib, sa, sb, r;
      logic err, dz, ovf, cy, zr;
      ia = int'(a); ib = int'(b);
      sa = (ia >= 128) ? ia - 256 : ia;
      sb = (ib >= 128) ? ib - 256 : ib;
      err = 0; dz = 0; ovf = 0; cy = 0; r = 0; e_hi = '0; e_lat = 1;
      case (o)
         4'd0: begin r = ia + ib; cy = (r > 255); ovf = (sa + sb > 127) || (sa + sb < -128); end
         4'd1: begin r = ia - ib; cy = (ia < ib); ovf = (sa - sb > 127) || (sa - sb < -128); end
         4'd2: r = ia | ib;
         4'd3: r = ia & ib;
         4'd4: r = ia ^ ib;
         4'd5: r = (sa < sb) ? 1 : 0;
         4'd6: r = ia << (ib % 8);
         4'd7: r = ia >> (ib % 8);
         4'd8: begin r = ia * ib; e_hi = 8'(r / 256); e_lat = 9; end
`ifdef SEQ_ALU_DIV_EN
         4'd9: begin
            e_lat = 9;
            if (ib == 0) begin r = 255; e_hi = a; dz = 1; end
            else begin r = ia / ib; e_hi = 8'(ia % ib); end
         end
`endif
         default: err = 1;
      endcase
      e_ans = err ? 8'h00 : 8'(r);
      zr = !err && (e_ans == 0) && (e_hi == 0);
      e_fl = {err, dz, ovf, cy, zr};
   endfunction

   // Issue one op, wait (bounded) for out_valid, capture outputs, then consume.
   task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r_ans, output logic [7:0] r_hi,
                         output logic [4:0] r_fl, output int lat, output bit rdy_bad);
      @(negedge clk);
      in_valid = 1'b1; op = o; inA = a; inB = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0; op = 4'($urandom); inA = 8'($urandom); inB = 8'($urandom);
      lat = 0;
      rdy_bad = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) rdy_bad = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      r_ans = ans; r_hi = ans_hi; r_fl = flags;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("release_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t       vecs[$];
      logic [7:0] r_ans, r_hi, e_ans, e_hi;
      logic [4:0] r_fl, e_fl;
      int         lat, e_lat;
      bit         rdy_bad, seen;

      // Reset state while rst_n is held low.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ans", 32'(ans), 32'd0);
      chk("rst_ans_hi", 32'(ans_hi), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // flags = {err, dz, ovf, carry, zero}
      vecs.push_back('{4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b00011, 1});
      vecs.push_back('{4'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b00100, 1});
      vecs.push_back('{4'd1, 8'h03, 8'h05, 8'hFE, 8'h00, 5'b00010, 1});
      vecs.push_back('{4'd5, 8'h80, 8'h01, 8'h01, 8'h00, 5'b00000, 1});
      vecs.push_back('{4'd5, 8'h01, 8'h80, 8'h00, 8'h00, 5'b00001, 1});
      vecs.push_back('{4'd2, 8'h0F, 8'hF0, 8'hFF, 8'h00, 5'b00000, 1});
      vecs.push_back('{4'd3, 8'h0F, 8'hF0, 8'h00, 8'h00, 5'b00001, 1});
      vecs.push_back('{4'd4, 8'hA5, 8'hFF, 8'h5A, 8'h00, 5'b00000, 1});
      vecs.push_back('{4'd6, 8'h81, 8'h09, 8'h02, 8'h00, 5'b00000, 1});
      vecs.push_back('{4'd7, 8'h80, 8'h0F, 8'h01, 8'h00, 5'b00000, 1});
      vecs.push_back('{4'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b00100, 1});
      vecs.push_back('{4'd8, 8'hC8, 8'h03, 8'h58, 8'h02, 5'b00000, 9});
      vecs.push_back('{4'd8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b00000, 9});
      vecs.push_back('{4'd8, 8'h00, 8'h37, 8'h00, 8'h00, 5'b00001, 9});
      vecs.push_back('{4'd12, 8'h12, 8'h34, 8'h00, 8'h00, 5'b10000, 1});
`ifdef SEQ_ALU_DIV_EN
      vecs.push_back('{4'd9, 8'h64, 8'h07, 8'h0E, 8'h02, 5'b00000, 9});
      vecs.push_back('{4'd9, 8'h05, 8'h00, 8'hFF, 8'h05, 5'b01000, 9});
`else
      vecs.push_back('{4'd9, 8'h64, 8'h07, 8'h00, 8'h00, 5'b10000, 1});
`endif

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_ans, r_hi, r_fl, lat, rdy_bad);
         chk($sformatf("vec%0d_ans", i), 32'(r_ans), 32'(vecs[i].ans));
         chk($sformatf("vec%0d_hi", i), 32'(r_hi), 32'(vecs[i].hi));
         chk($sformatf("vec%0d_flags", i), 32'(r_fl), 32'(vecs[i].fl));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("vec%0d_busy_in_ready", i), 32'(rdy_bad), 32'd0);
      end

      // Backpressure: result held, new requests ignored while DONE.
      @(negedge clk);
      in_valid = 1'b1; op = 4'd0; inA = 8'h10; inB = 8'h20;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp_latency", 32'(lat), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1; op = 4'($urandom_range(0, 8)); inA = 8'($urandom); inB = 8'($urandom);
         @(posedge clk);
         #1;
         chk($sformatf("bp_ans_%0d", k), 32'(ans), 32'h30);
         chk($sformatf("bp_flags_%0d", k), 32'(flags), 32'd0);
         chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
         chk($sformatf("bp_out_valid_%0d", k), 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("bp_no_second_accept", 32'(seen), 32'd0);

      // out_ready held high from before accept: no effect until DONE.
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 4'd8; inA = 8'hC8; inB = 8'h03;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("early_rdy_latency", 32'(lat), 32'd9);
      chk("early_rdy_ans", 32'(ans), 32'h58);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("early_rdy_out_valid", 32'(out_valid), 32'd0);
      chk("early_rdy_in_ready", 32'(in_ready), 32'd1);

      // Reset asserted during the 4th BUSY cycle of a MUL.
      run_op(4'd0, 8'h01, 8'h01, r_ans, r_hi, r_fl, lat, rdy_bad);
      chk("pre_rst_ans", 32'(r_ans), 32'h02);
      @(negedge clk);
      in_valid = 1'b1; op = 4'd8; inA = 8'hC8; inB = 8'h03;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ans", 32'(ans), 32'd0);
      chk("midrst_ans_hi", 32'(ans_hi), 32'd0);
      chk("midrst_flags", 32'(flags), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (14) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_out_valid", 32'(seen), 32'd0);

      // Random ops against the model.
      for (int n = 0; n < 200; n++) begin
         logic [3:0] ro;
         logic [7:0] ra, rb;
         ro = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 9)) : 4'($urandom_range(0, 15));
         ra = 8'($urandom);
         rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         model(ro, ra, rb, e_ans, e_hi, e_fl, e_lat);
         run_op(ro, ra, rb, r_ans, r_hi, r_fl, lat, rdy_bad);
         chk($sformatf("rnd%0d_op%0d_ans", n, ro), 32'(r_ans), 32'(e_ans));
         chk($sformatf("rnd%0d_op%0d_hi", n, ro), 32'(r_hi), 32'(e_hi));
         chk($sformatf("rnd%0d_op%0d_flags", n, ro), 32'(r_fl), 32'(e_fl));
         chk($sformatf("rnd%0d_op%0d_latency", n, ro), 32'(lat), 32'(e_lat));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
